// File: rtl/counter_sequencer_pkg.sv
// Shared types and constants for the counter sequencer slice: FSM state
// encoding, the "skip this phase" period value and the period table entry.
package counter_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } seq_state_t;

  // Nominal software-visible period width; the default for WIDTH.
  localparam int PERIOD_W = 32;

  // One entry of the period table as software writes it.
  typedef logic [PERIOD_W-1:0] period_t;

  // A table entry holding this value is skipped without counting.
  localparam period_t SKIP_PERIOD = '0;

endpackage

// File: rtl/counter_sequencer_if.sv
// Control/status bundle between surrounding logic (master) and the
// sequencer (slave), plus debug visibility of the FSM and the counter link.
interface counter_sequencer_if
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = PERIOD_W,
  parameter int IDX_W = 2
);

  logic             start;
  logic             stop;
  logic             loop;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_addr;
  logic [WIDTH-1:0] cfg_data;
  logic             busy;
  logic [IDX_W-1:0] phase;
  logic             phase_strobe;
  logic             done;

  // Debug view: FSM state and the sequencer-to-counter handshake.
  seq_state_t       dbg_state;
  logic             dbg_enable;
  logic             dbg_ready;
  logic             dbg_clear;

  modport master (
    output start, stop, loop, cfg_we, cfg_addr, cfg_data,
    input  busy, phase, phase_strobe, done,
    input  dbg_state, dbg_enable, dbg_ready, dbg_clear
  );

  modport slave (
    input  start, stop, loop, cfg_we, cfg_addr, cfg_data,
    output busy, phase, phase_strobe, done,
    output dbg_state, dbg_enable, dbg_ready, dbg_clear
  );

endinterface

// File: rtl/counter_sequencer_counter.sv
// Strobe counter: while held in rst it drops ready; LATENCY cycles after rst
// releases it raises ready, having captured reset_value in the meantime.
// Each accepted enable counts down by one; strobe is high once the count is
// exhausted and stays high until the next rst. LATENCY must be at least 1 so
// that the capture cycle exists.
module counter_with_strobe #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] reset_value,
  output logic             ready,
  output logic             strobe
);

  localparam int LAT_W = $clog2(LATENCY + 1);

  logic [LAT_W-1:0] lat_q;
  logic [WIDTH-1:0] cnt_q;

  assign ready  = (lat_q == LAT_W'(LATENCY));
  assign strobe = ready & (cnt_q == '0);

  // Ready latency after clear, period capture, then count down on enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_q <= '0;
      cnt_q <= '0;
    end else if (!ready) begin
      lat_q <= lat_q + 1'b1;
      cnt_q <= reset_value;
    end else if (enable && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Sequencer: walks a programmable table of periods, running one strobe
// counter per phase, and reports phase ends and sequence completion.
//
// Counter handshake: enable is a request the counter consumes only on a
// cycle where ready=1. The sequencer raises enable only while ready=1, never
// in the strobe cycle, and never while stop/rst is active. reset_value is
// only rewritten in LOAD, a cycle in which the counter is held cleared.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH   = PERIOD_W,
  parameter int LATENCY = 1,
  parameter int STEPS   = 4,
  parameter int IDX_W   = $clog2(STEPS)
) (
  input  logic              clk,
  input  logic              rst,
  counter_sequencer_if.slave bus
);

  localparam int               SKIP_W = $clog2(STEPS + 1);
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(STEPS - 1);

  seq_state_t        state_q;
  logic [IDX_W-1:0]  phase_q;
  logic [SKIP_W-1:0] skip_q;
  logic              done_q;
  logic [WIDTH-1:0]  reset_value_q;
  logic [WIDTH-1:0]  table_q [STEPS];

  logic [WIDTH-1:0]  cur_entry;
  logic              is_last;
  logic              in_run;
  logic              cnt_enable;
  logic              cnt_clear;
  logic              cnt_ready;
  logic              cnt_strobe;

  assign cur_entry = table_q[phase_q];
  assign is_last   = (phase_q == LAST);
  assign in_run    = (state_q == ST_RUN);

  assign cnt_enable = in_run & cnt_ready & ~cnt_strobe & ~bus.stop & ~rst;
  assign cnt_clear  = rst | (state_q == ST_LOAD) | bus.stop;

  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.phase        = phase_q;
  assign bus.phase_strobe = in_run & cnt_strobe & ~bus.stop;
  assign bus.done         = done_q;
  assign bus.dbg_state    = state_q;
  assign bus.dbg_enable   = cnt_enable;
  assign bus.dbg_ready    = cnt_ready;
  assign bus.dbg_clear    = cnt_clear;

  counter_with_strobe #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) u_counter (
    .clk         (clk),
    .rst         (cnt_clear),
    .enable      (cnt_enable),
    .reset_value (reset_value_q),
    .ready       (cnt_ready),
    .strobe      (cnt_strobe)
  );

  // Period table: written in any state, deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (bus.cfg_we) begin
      table_q[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  // Phase FSM: load period, run counter, advance/wrap/finish; stop aborts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      phase_q       <= '0;
      skip_q        <= '0;
      done_q        <= 1'b0;
      reset_value_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.stop) begin
        state_q <= ST_IDLE;
        phase_q <= '0;
        skip_q  <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.start) begin
              phase_q <= '0;
              skip_q  <= '0;
              state_q <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            if (cur_entry != WIDTH'(SKIP_PERIOD)) begin
              reset_value_q <= cur_entry;
              skip_q        <= '0;
              state_q       <= ST_RUN;
            end else if (skip_q == SKIP_W'(STEPS - 1)) begin
              // Every entry skipped in a row: end even when looping.
              skip_q  <= '0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              skip_q <= skip_q + 1'b1;
              if (!is_last) begin
                phase_q <= phase_q + 1'b1;
              end else if (bus.loop) begin
                phase_q <= '0;
              end else begin
                done_q  <= 1'b1;
                state_q <= ST_IDLE;
              end
            end
          end
          ST_RUN: begin
            if (cnt_strobe) begin
              if (!is_last) begin
                phase_q <= phase_q + 1'b1;
                state_q <= ST_LOAD;
              end else if (bus.loop) begin
                phase_q <= '0;
                state_q <= ST_LOAD;
              end else begin
                done_q  <= 1'b1;
                state_q <= ST_IDLE;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: programs period tables, runs
// sequences and compares per-phase enable counts, phases and status pulses
// against hand-computed expectations.
module tb_counter_sequencer;
  import counter_seq_pkg::*;

  localparam int WIDTH   = 32;
  localparam int LATENCY = 1;
  localparam int STEPS   = 4;
  localparam int IDX_W   = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  counter_sequencer_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

  counter_sequencer #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY),
    .STEPS   (STEPS),
    .IDX_W   (IDX_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_ph_q[$];
  logic [31:0] obs_cnt_q[$];
  logic [31:0] obs_ph_q[$];
  int          done_seen;
  int          load_cycles;
  int          first_en_k;
  int          total_en;
  int          bad_en;
  logic        busy_at_done;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_cfg(input int addr, input logic [31:0] data);
    logic [31:0] a;
    a = addr;
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = a[IDX_W-1:0];
    bus.cfg_data = data;
    @(posedge clk);
    #1 bus.cfg_we = 1'b0;
  endtask

  task automatic load_table(input logic [31:0] p0, input logic [31:0] p1,
                            input logic [31:0] p2, input logic [31:0] p3);
    write_cfg(0, p0);
    write_cfg(1, p1);
    write_cfg(2, p2);
    write_cfg(3, p3);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Monitor a sequence until done (bounded); sample k=0 is the first LOAD.
  task automatic run_seq(input int budget, input int loop_off_after);
    int en_cnt;
    int k;
    bit fin;
    en_cnt = 0;
    k = 0;
    fin = 1'b0;
    obs_cnt_q.delete();
    obs_ph_q.delete();
    done_seen = 0;
    load_cycles = 0;
    first_en_k = -1;
    total_en = 0;
    bad_en = 0;
    busy_at_done = 1'b1;
    while (!fin && k < budget) begin
      @(negedge clk);
      if (bus.dbg_state == ST_LOAD) load_cycles++;
      if (bus.dbg_enable) begin
        en_cnt++;
        total_en++;
        if (first_en_k < 0) first_en_k = k;
        if (!bus.dbg_ready) bad_en++;
      end
      if (bus.phase_strobe) begin
        if (bus.dbg_enable) bad_en++;
        obs_cnt_q.push_back(en_cnt);
        obs_ph_q.push_back(32'(bus.phase));
        en_cnt = 0;
        if (loop_off_after != 0 && obs_cnt_q.size() == loop_off_after) bus.loop = 1'b0;
      end
      if (bus.done) begin
        done_seen++;
        busy_at_done = bus.busy;
        fin = 1'b1;
      end
      k++;
    end
    check("seq_finished", fin, 1);
    check("enable_rules", bad_en, 0);
  endtask

  task automatic check_strobes(input string tag);
    check({tag, "_nstrobes"}, obs_cnt_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs_cnt_q.size()) begin
        check($sformatf("%s_cnt%0d", tag, i), obs_cnt_q[i], exp_q[i]);
        check($sformatf("%s_ph%0d", tag, i), obs_ph_q[i], exp_ph_q[i]);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1);
  end

  initial begin : main
    bit hit;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.loop     = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_phase", bus.phase, 0);
    check("rst_done", bus.done, 0);
    check("rst_pstrobe", bus.phase_strobe, 0);
    check("rst_enable", bus.dbg_enable, 0);
    check("rst_clear", bus.dbg_clear, 1);
    check("rst_state", bus.dbg_state, ST_IDLE);
    rst = 1'b0;

    // Plain sequence {3,2,4,1}, no loop.
    load_table(3, 2, 4, 1);
    bus.loop = 1'b0;
    pulse_start();
    run_seq(200, 0);
    exp_q = '{3, 2, 4, 1};
    exp_ph_q = '{0, 1, 2, 3};
    check_strobes("seq1");
    check("seq1_first_en", first_en_k, 2);
    check("seq1_done_cnt", done_seen, 1);
    check("seq1_busy_at_done", busy_at_done, 0);
    @(negedge clk);
    check("seq1_done_pulse", bus.done, 0);
    check("seq1_idle", bus.dbg_state, ST_IDLE);

    // Skipped middle phases {2,0,0,3}.
    load_table(2, 0, 0, 3);
    pulse_start();
    run_seq(200, 0);
    exp_q = '{2, 3};
    exp_ph_q = '{0, 3};
    check_strobes("skip");
    check("skip_loads", load_cycles, 4);
    check("skip_done_cnt", done_seen, 1);

    // All-zero table with loop set: guard ends after STEPS loads.
    load_table(0, 0, 0, 0);
    bus.loop = 1'b1;
    pulse_start();
    run_seq(50, 0);
    check("zero_nstrobes", obs_cnt_q.size(), 0);
    check("zero_enables", total_en, 0);
    check("zero_loads", load_cycles, STEPS);
    check("zero_done_cnt", done_seen, 1);
    bus.loop = 1'b0;

    // start together with stop in IDLE: stop wins.
    @(negedge clk);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.stop = 1'b0;
    @(negedge clk);
    check("stopstart_state", bus.dbg_state, ST_IDLE);
    check("stopstart_busy", bus.busy, 0);

    // Stop during phase 1 after one enable.
    load_table(2, 2, 2, 2);
    bus.loop = 1'b1;
    pulse_start();
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge clk);
      if (bus.phase == 2'd1 && bus.dbg_enable) hit = 1'b1;
    end
    check("stop_reach", hit, 1);
    @(posedge clk);
    #1 bus.stop = 1'b1;
    @(negedge clk);
    check("stop_enable", bus.dbg_enable, 0);
    check("stop_clear", bus.dbg_clear, 1);
    check("stop_pstrobe", bus.phase_strobe, 0);
    check("stop_done_during", bus.done, 0);
    @(posedge clk);
    #1 bus.stop = 1'b0;
    @(negedge clk);
    check("stop_state", bus.dbg_state, ST_IDLE);
    check("stop_phase", bus.phase, 0);
    check("stop_busy", bus.busy, 0);
    check("stop_done_after", bus.done, 0);
    bus.loop = 1'b0;
    pulse_start();
    run_seq(200, 0);
    exp_q = '{2, 2, 2, 2};
    exp_ph_q = '{0, 1, 2, 3};
    check_strobes("restart");

    // Rewrite active entry 0 mid-RUN: takes effect on the next pass.
    load_table(5, 1, 1, 1);
    bus.loop = 1'b1;
    pulse_start();
    fork
      run_seq(400, 5);
      begin
        repeat (4) @(negedge clk);
        write_cfg(0, 2);
      end
    join
    exp_q = '{5, 1, 1, 1, 2, 1, 1, 1};
    exp_ph_q = '{0, 1, 2, 3, 0, 1, 2, 3};
    check_strobes("rewrite");
    check("rewrite_done_cnt", done_seen, 1);

    // Reset mid-RUN together with start.
    load_table(3, 2, 4, 1);
    bus.loop = 1'b0;
    pulse_start();
    repeat (4) @(negedge clk);
    check("rstrun_in_run", bus.dbg_state, ST_RUN);
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    check("rstrun_busy", bus.busy, 0);
    check("rstrun_phase", bus.phase, 0);
    check("rstrun_pstrobe", bus.phase_strobe, 0);
    check("rstrun_done", bus.done, 0);
    check("rstrun_enable", bus.dbg_enable, 0);
    @(negedge clk);
    check("rstrun_enable2", bus.dbg_enable, 0);
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("rstrun_idle", bus.dbg_state, ST_IDLE);
    pulse_start();
    run_seq(200, 0);
    exp_q = '{3, 2, 4, 1};
    exp_ph_q = '{0, 1, 2, 3};
    check_strobes("after_rst");
    check("after_rst_done_cnt", done_seen, 1);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
